// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two requesters, the arbiter and the register file write port.
interface regfile_wb_arbiter_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;
  logic              WE3;
  logic              init_done;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output A3, WD3, WE3, init_done
  );

  // Requester / register-file side.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  A3, WD3, WE3, init_done
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Owns the register file write port: clears x1..x(NUM_REGS-1) after reset, then
// round-robin arbitrates two write-back requesters onto the port.
module regfile_wb_arbiter #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] init_ptr_q;
  logic              last_grant_q;
  logic [ADDR_W-1:0] a3_q;
  logic [DATA_W-1:0] wd3_q;
  logic              we3_q;
  logic              init_done_q;
  logic              grant0_c;
  logic              grant1_c;

  // Same-cycle grant; on contention the requester not served last wins.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (state_q == ST_RUN) begin
      if (bus.req0_valid && (!bus.req1_valid || last_grant_q)) begin
        grant0_c = 1'b1;
      end else if (bus.req1_valid) begin
        grant1_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      init_ptr_q   <= ADDR_W'(1);
      last_grant_q <= 1'b1;
      a3_q         <= '0;
      wd3_q        <= '0;
      we3_q        <= 1'b0;
      init_done_q  <= 1'b0;
    end else if (state_q == ST_INIT) begin
      a3_q       <= init_ptr_q;
      wd3_q      <= '0;
      we3_q      <= 1'b1;
      init_ptr_q <= init_ptr_q + ADDR_W'(1);
      if (init_ptr_q == LAST_ADDR) begin
        state_q     <= ST_RUN;
        init_done_q <= 1'b1;
      end
    end else begin
      // Writes to x0 still complete the handshake but never enable the port.
      if (grant0_c) begin
        a3_q         <= bus.req0_addr;
        wd3_q        <= bus.req0_data;
        we3_q        <= (bus.req0_addr != '0);
        last_grant_q <= 1'b0;
      end else if (grant1_c) begin
        a3_q         <= bus.req1_addr;
        wd3_q        <= bus.req1_data;
        we3_q        <= (bus.req1_addr != '0);
        last_grant_q <= 1'b1;
      end else begin
        we3_q <= 1'b0;
      end
    end
  end

  assign bus.req0_ready = grant0_c;
  assign bus.req1_ready = grant1_c;
  assign bus.A3         = a3_q;
  assign bus.WD3        = wd3_q;
  assign bus.WE3        = we3_q;
  assign bus.init_done  = init_done_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a cycle model predicts each port write,
// a monitor compares the register file port one cycle later.
module tb_regfile_wb_arbiter;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  regfile_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int                cyc;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              done;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: counts clears, then serves requests round-robin.
  int unsigned       cleared;
  logic              served_last;
  logic [ADDR_W-1:0] port_a;
  logic [DATA_W-1:0] port_d;
  logic              g0, g1;
  exp_t              e;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      cleared     = 0;
      served_last = 1'b1;
      port_a      = '0;
      port_d      = '0;
    end else begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (cleared >= NUM_REGS - 1) begin
        if (bus.req0_valid && bus.req1_valid) begin
          g0 = (served_last == 1'b1);
          g1 = !g0;
        end else begin
          g0 = bus.req0_valid;
          g1 = bus.req1_valid;
        end
      end
      chk("req0_ready", 32'(bus.req0_ready), 32'(g0));
      chk("req1_ready", 32'(bus.req1_ready), 32'(g1));
      e.cyc = cyc + 1;
      if (cleared < NUM_REGS - 1) begin
        cleared = cleared + 1;
        port_a  = ADDR_W'(cleared);
        port_d  = '0;
        e.we    = 1'b1;
        e.done  = (cleared == NUM_REGS - 1);
      end else begin
        e.done = 1'b1;
        e.we   = 1'b0;
        if (g0) begin
          port_a = bus.req0_addr; port_d = bus.req0_data; served_last = 1'b0;
          e.we = (bus.req0_addr != 0);
        end else if (g1) begin
          port_a = bus.req1_addr; port_d = bus.req1_data; served_last = 1'b1;
          e.we = (bus.req1_addr != 0);
        end
      end
      e.a = port_a;
      e.d = port_d;
      exp_q.push_back(e);
    end
  end

  // Monitor: checks reset values, otherwise pops the prediction for this cycle.
  exp_t m;
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_WE3", 32'(bus.WE3), 32'd0);
      chk("rst_A3", 32'(bus.A3), 32'd0);
      chk("rst_WD3", bus.WD3, 32'd0);
      chk("rst_init_done", 32'(bus.init_done), 32'd0);
      chk("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        m = exp_q.pop_front();
        chk("WE3", 32'(bus.WE3), 32'(m.we));
        chk("A3", 32'(bus.A3), 32'(m.a));
        chk("WD3", bus.WD3, m.d);
        chk("init_done", 32'(bus.init_done), 32'(m.done));
      end
    end
  end

  task automatic set_req(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.init_done) ok = 1'b1;
    end
    chk("init_done_timeout", 32'(ok), 32'd1);
  endtask

  task automatic random_phase(input int n);
    logic r0, r1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      r0 = bus.req0_ready;
      r1 = bus.req1_ready;
      next_cycle();
      if (!bus.req0_valid || r0) begin
        bus.req0_valid = ($urandom_range(2) != 0);
        bus.req0_addr  = ADDR_W'($urandom_range(7));
        bus.req0_data  = $urandom;
      end else if ($urandom_range(7) == 0) begin
        bus.req0_valid = 1'b0;
      end
      if (!bus.req1_valid || r1) begin
        bus.req1_valid = ($urandom_range(2) != 0);
        bus.req1_addr  = ADDR_W'($urandom_range(7));
        bus.req1_data  = $urandom;
      end else if ($urandom_range(7) == 0) begin
        bus.req1_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    logic found;
    // Reset with req0 already pending, then the full clear sequence.
    set_req(1'b1, 5'd9, 32'd1, 1'b0, 5'd0, 32'd0);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    wait_init();

    // Single requester, round-robin contention, and an x0 write.
    next_cycle(); set_req(1'b1, 5'd5, 32'd100, 1'b0, 5'd0, 32'd0);
    next_cycle(); set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    next_cycle(); set_req(1'b1, 5'd2, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB);
    repeat (3) @(posedge clk);
    #1 set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    next_cycle(); set_req(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd7);
    next_cycle(); set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    next_cycle();

    random_phase(400);
    next_cycle(); set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    next_cycle();

    // Reset mid-clear at A3=10; the clear restarts from x1.
    reset = 1'b0;
    next_cycle(); reset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.WE3 && bus.A3 == 5'd10) found = 1'b1;
    end
    chk("a3_10_timeout", 32'(found), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_WE3", 32'(bus.WE3), 32'd0);
    chk("async_A3", 32'(bus.A3), 32'd0);
    chk("async_init_done", 32'(bus.init_done), 32'd0);
    next_cycle(); next_cycle(); reset = 1'b1;
    wait_init();

    // Reset during RUN while a write is on the port and req0 is granted.
    next_cycle(); set_req(1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
    next_cycle(); set_req(1'b1, 5'd8, 32'h0BAD_F00D, 1'b0, 5'd0, 32'd0);
    #1;
    chk("run_ready0", 32'(bus.req0_ready), 32'd1);
    chk("run_WE3", 32'(bus.WE3), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_run_WE3", 32'(bus.WE3), 32'd0);
    chk("async_run_ready0", 32'(bus.req0_ready), 32'd0);
    next_cycle(); next_cycle(); reset = 1'b1;
    wait_init();
    next_cycle(); next_cycle(); set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (3) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
